rc_cmd_receiver: RTL

//  Serial receiver/decoder for the remote-control (DU) link; upstream stage of the robot motor FSM.

---
 rtl/robot_pkg.sv | 40 ++++
 rtl/rc_uart_rx_core.sv | 100 ++++++++++
 rtl/rc_cmd_receiver.sv | 74 +++++++
 3 files changed

// File: rtl/robot_pkg.sv
// Shared definitions for the remote-control link and the robot motor FSM:
// move codes, receiver FSM states, command byte layout and frame integrity rule.
package robot_pkg;

    typedef enum logic [2:0] {
        MV_STOP   = 3'b000,
        MV_ALT_R  = 3'b001,
        MV_ALT_L  = 3'b010,
        MV_BACK   = 3'b011,
        MV_LEFT   = 3'b101,
        MV_RIGHT  = 3'b110,
        MV_FWRD   = 3'b111
    } move_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam int unsigned FB_MOTOR    = 7;
    localparam int unsigned FB_NMOVE_HI = 6;
    localparam int unsigned FB_NMOVE_LO = 4;
    localparam int unsigned FB_RSVD     = 3;
    localparam int unsigned FB_MOVE_HI  = 2;
    localparam int unsigned FB_MOVE_LO  = 0;

    localparam logic [2:0] MV_ILLEGAL = 3'b100;

    // Inverted copy of move must match, reserved bit clear, 100 never a legal move.
    function automatic logic frame_ok(input logic [7:0] b);
        logic [2:0] mv;
        logic [2:0] nmv;
        mv  = b[FB_MOVE_HI:FB_MOVE_LO];
        nmv = b[FB_NMOVE_HI:FB_NMOVE_LO];
        return (nmv == ~mv) && !b[FB_RSVD] && (mv != MV_ILLEGAL);
    endfunction

endpackage

// File: rtl/rc_uart_rx_core.sv
// 8N1 serial receiver: 2-FF synchroniser plus bit-level FSM, yields one byte
// strobe or stop-bit error strobe in the stop-bit sample cycle.
module rc_uart_rx_core
    import robot_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       stop_err_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       sync_q;
    logic             rxs;
    logic             rxs_d_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;

    assign rxs    = sync_q[1];
    assign byte_o = shift_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '1;
            rxs_d_q <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            rxs_d_q <= rxs;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_o = 1'b0;
        stop_err_o   = 1'b0;
        case (state_q)
            // Only a true falling edge starts a frame, so a line still low after a bad stop bit is ignored.
            RX_IDLE: begin
                if (rxs_d_q && !rxs) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rxs ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    state_d      = RX_IDLE;
                    byte_valid_o = rxs;
                    stop_err_o   = !rxs;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/rc_cmd_receiver.sv
// Remote-control command receiver: decodes link bytes into motor_on/move for the
// robot FSM, flags corrupt frames and forces a stop when the link goes silent.
module rc_cmd_receiver
    import robot_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       motor_on_o,
    output logic [2:0] move_o,
    output logic       cmd_valid_o,
    output logic       frame_err_o,
    output logic       link_lost_o
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [7:0]      rx_byte;
    logic            byte_valid;
    logic            stop_err;
    logic            cmd_ok;
    logic            cmd_bad;
    logic [WD_W-1:0] wd_q;

    rc_uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_core (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .byte_o      (rx_byte),
        .byte_valid_o(byte_valid),
        .stop_err_o  (stop_err)
    );

    always_comb begin
        cmd_ok  = byte_valid && frame_ok(rx_byte);
        cmd_bad = (byte_valid && !frame_ok(rx_byte)) || stop_err;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            motor_on_o  <= 1'b0;
            move_o      <= MV_STOP;
            cmd_valid_o <= 1'b0;
            frame_err_o <= 1'b0;
            link_lost_o <= 1'b1;
            wd_q        <= '0;
        end else begin
            cmd_valid_o <= 1'b0;
            frame_err_o <= cmd_bad;
            // A valid frame takes priority over a watchdog expiry in the same cycle.
            if (cmd_ok) begin
                motor_on_o  <= rx_byte[FB_MOTOR];
                move_o      <= rx_byte[FB_MOVE_HI:FB_MOVE_LO];
                cmd_valid_o <= 1'b1;
                link_lost_o <= 1'b0;
                wd_q        <= '0;
            end else if (!link_lost_o) begin
                if (wd_q == WD_LAST) begin
                    link_lost_o <= 1'b1;
                    move_o      <= MV_STOP;
                end else begin
                    wd_q <= wd_q + WD_W'(1);
                end
            end
        end
    end

endmodule
